// File: rtl/lane_tb_pkg.sv
// Shared types, LFSR tap constants and the golden arithmetic model for the
// lane stimulus/check engine.
package lane_tb_pkg;

   // Operation applied by the DUT to each operand pair
   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      XOR = 2'b11
   } mode_e;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_e;

   // Fibonacci tap masks (bit i set = stage i+1 feeds the XOR), maximal length
   localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
   localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
   localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
   localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

   function automatic logic [63:0] lfsr_taps(input int unsigned width);
      logic [63:0] taps;
      case (width)
         8:       taps = TAPS_8;
         16:      taps = TAPS_16;
         32:      taps = TAPS_32;
         64:      taps = TAPS_64;
         default: taps = TAPS_32;
      endcase
      return taps;
   endfunction

   // Reference result at full 64-bit width; callers truncate to their WIDTH,
   // which is exact modular arithmetic for add/sub.
   function automatic logic [63:0] golden(input mode_e mode,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
      logic [63:0] res;
      case (mode)
         ADD:     res = a + b;
         SUB:     res = a - b;
         AND:     res = a & b;
         XOR:     res = a ^ b;
         default: res = a + b;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lane_testbench_lfsr_gen.sv
// Fibonacci LFSR operand source; advances only when step is high.
module lfsr_gen
   import lane_tb_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter logic [63:0] SEED  = 64'h0000_0000_CAFE_F00D
) (
   input  logic             clk_dut,
   input  logic             reset,
   input  logic             step,
   output logic [WIDTH-1:0] o_value
);

   localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
   localparam logic [WIDTH-1:0] SEED_T = SEED[WIDTH-1:0];

   logic [WIDTH-1:0] r_value;
   logic             w_fb;

   assign w_fb    = ^(r_value & TAPS);
   assign o_value = r_value;

   // Shift register: seed on reset, shift in feedback on each step
   always_ff @(posedge clk_dut) begin
      if (reset) begin
         r_value <= SEED_T;
      end else if (step) begin
         r_value <= {r_value[WIDTH-2:0], w_fb};
      end
   end

endmodule

// File: rtl/lane_testbench.sv
// Stimulus/check engine for one pipelined arithmetic DUT: drives LFSR operands,
// realigns them through a valid-tagged delay line of LATENCY stages, compares
// the DUT result against the golden model and counts samples and mismatches.
// Optional first-mismatch capture is built when LANE_TB_ERR_CAPTURE_EN is defined.
module lane_testbench
   import lane_tb_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 2,
   parameter logic [63:0] SEED_A  = 64'h0000_0000_CAFE_F00D,
   parameter logic [63:0] SEED_B  = 64'h0000_0000_FEED_C0DE
) (
   input  logic             clk_dut,
   input  logic             reset,
   input  logic             enable,
   input  logic             freeze,
   input  logic [1:0]       i_mode,
   output logic [WIDTH-1:0] o_drive_a,
   output logic [WIDTH-1:0] o_drive_b,
   output logic             o_drive_valid,
   input  logic [WIDTH-1:0] i_dut_out,
   output logic [WIDTH-1:0] o_data_ctr,
   output logic [WIDTH-1:0] o_event_ctr,
   output logic [WIDTH-1:0] o_err_a,
   output logic [WIDTH-1:0] o_err_b,
   output logic             o_err_valid
);

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0]   w_lfsr_a;
   logic [WIDTH-1:0]   w_lfsr_b;
   logic [WIDTH-1:0]   r_drive_a;
   logic [WIDTH-1:0]   r_drive_b;
   logic               r_drive_valid;
   mode_e              r_mode;
   logic [LATENCY-1:0] r_dl_valid;
   logic [WIDTH-1:0]   r_dl_a [LATENCY];
   logic [WIDTH-1:0]   r_dl_b [LATENCY];
   mode_e              r_dl_mode [LATENCY];
   logic [WIDTH-1:0]   w_expect;
   logic               w_last_valid;
   logic               w_mismatch;
   logic [WIDTH-1:0]   r_data_ctr;
   logic [WIDTH-1:0]   r_event_ctr;
   state_e             r_state;
   state_e             w_next;

   lfsr_gen #(.WIDTH(WIDTH), .SEED(SEED_A)) u_lfsr_a (
      .clk_dut (clk_dut),
      .reset   (reset),
      .step    (enable),
      .o_value (w_lfsr_a)
   );

   lfsr_gen #(.WIDTH(WIDTH), .SEED(SEED_B)) u_lfsr_b (
      .clk_dut (clk_dut),
      .reset   (reset),
      .step    (enable),
      .o_value (w_lfsr_b)
   );

   // Register the current LFSR values and the issue mode toward the DUT
   always_ff @(posedge clk_dut) begin
      if (reset) begin
         r_drive_a     <= ZERO;
         r_drive_b     <= ZERO;
         r_drive_valid <= 1'b0;
         r_mode        <= ADD;
      end else begin
         r_drive_a     <= w_lfsr_a;
         r_drive_b     <= w_lfsr_b;
         r_drive_valid <= enable;
         r_mode        <= mode_e'(i_mode);
      end
   end

   // Delay line matching the DUT pipeline; shifts every cycle
   always_ff @(posedge clk_dut) begin
      if (reset) begin
         r_dl_valid <= {LATENCY{1'b0}};
         for (int unsigned i = 0; i < LATENCY; i++) begin
            r_dl_a[i]    <= ZERO;
            r_dl_b[i]    <= ZERO;
            r_dl_mode[i] <= ADD;
         end
      end else begin
         r_dl_valid[0] <= r_drive_valid;
         r_dl_a[0]     <= r_drive_a;
         r_dl_b[0]     <= r_drive_b;
         r_dl_mode[0]  <= r_mode;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            r_dl_valid[i] <= r_dl_valid[i-1];
            r_dl_a[i]     <= r_dl_a[i-1];
            r_dl_b[i]     <= r_dl_b[i-1];
            r_dl_mode[i]  <= r_dl_mode[i-1];
         end
      end
   end

   assign w_last_valid = r_dl_valid[LATENCY-1];
   assign w_expect     = WIDTH'(golden(r_dl_mode[LATENCY-1],
                                       64'(r_dl_a[LATENCY-1]),
                                       64'(r_dl_b[LATENCY-1])));
   assign w_mismatch   = w_last_valid && (i_dut_out != w_expect);

   // Saturating sample and mismatch counters, held while freeze is high
   always_ff @(posedge clk_dut) begin
      if (reset) begin
         r_data_ctr  <= ZERO;
         r_event_ctr <= ZERO;
      end else begin
         if (w_last_valid && !freeze && (r_data_ctr != ALL_ONES)) begin
            r_data_ctr <= r_data_ctr + ONE;
         end
         if (w_mismatch && !freeze && (r_event_ctr != ALL_ONES)) begin
            r_event_ctr <= r_event_ctr + ONE;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_dut) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic; DRAIN returns to IDLE once nothing is in flight
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (enable) w_next = RUN;
            else        w_next = IDLE;
         end
         RUN: begin
            if (!enable) w_next = DRAIN;
            else         w_next = RUN;
         end
         DRAIN: begin
            if (enable)                                 w_next = RUN;
            else if (!r_drive_valid && !(|r_dl_valid))  w_next = IDLE;
            else                                        w_next = DRAIN;
         end
         default: w_next = IDLE;
      endcase
   end

   assign o_drive_a     = r_drive_a;
   assign o_drive_b     = r_drive_b;
   assign o_drive_valid = r_drive_valid;
   assign o_data_ctr    = r_data_ctr;
   assign o_event_ctr   = r_event_ctr;

`ifdef LANE_TB_ERR_CAPTURE_EN
   logic [WIDTH-1:0] r_err_a;
   logic [WIDTH-1:0] r_err_b;
   logic             r_err_valid;

   // Latch operands of the first mismatch after reset; freeze does not apply
   always_ff @(posedge clk_dut) begin
      if (reset) begin
         r_err_a     <= ZERO;
         r_err_b     <= ZERO;
         r_err_valid <= 1'b0;
      end else if (w_mismatch && !r_err_valid) begin
         r_err_a     <= r_dl_a[LATENCY-1];
         r_err_b     <= r_dl_b[LATENCY-1];
         r_err_valid <= 1'b1;
      end
   end

   assign o_err_a     = r_err_a;
   assign o_err_b     = r_err_b;
   assign o_err_valid = r_err_valid;
`else
   assign o_err_a     = ZERO;
   assign o_err_b     = ZERO;
   assign o_err_valid = 1'b0;
`endif

endmodule
